// File: rtl/register_f_banked.sv
// Banked flag register with masked writes, bank rotation and an optional save stack.
// The save stack is built only when REGISTER_F_STACK_EN is defined.
module register_f_banked #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BANKS = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic [WIDTH-1:0]             FlagIn,
  input  logic [WIDTH-1:0]             FlagWriteMask,
  input  logic                         BankLoad,
  input  logic [WIDTH-1:0]             DataIn,
  input  logic                         Ex,
  input  logic                         Push,
  input  logic                         Pop,
  output logic [WIDTH-1:0]             F,
  output logic [WIDTH-1:0]             notF,
  output logic [WIDTH-1:0]             ShadowF,
  output logic [$clog2(DEPTH+1)-1:0]   StackCount,
  output logic                         StackFull,
  output logic                         StackEmpty,
  output logic                         StackError
);

  localparam int unsigned AW = (BANKS > 1) ? $clog2(BANKS) : 1;

  logic [WIDTH-1:0] r_bank [BANKS];
  logic [AW-1:0]    r_active;
  logic [AW-1:0]    w_next_active;
  logic [WIDTH-1:0] w_cur;
  logic [WIDTH-1:0] w_lw_d;
  logic             w_lw_we;
  logic [WIDTH-1:0] w_bank_d;
  logic             w_bank_we;

  assign w_next_active = (r_active == AW'(BANKS - 1)) ? '0 : r_active + AW'(1);
  assign w_cur         = r_bank[r_active];

  assign F       = w_cur;
  assign notF    = ~w_cur;
  assign ShadowF = r_bank[w_next_active];

  // BankLoad beats the masked write; this is the lowest tier of the command priority.
  always_comb begin
    w_lw_we = 1'b0;
    w_lw_d  = w_cur;
    if (BankLoad) begin
      w_lw_we = 1'b1;
      w_lw_d  = DataIn;
    end else if (|FlagWriteMask) begin
      w_lw_we = 1'b1;
      w_lw_d  = (w_cur & ~FlagWriteMask) | (FlagIn & FlagWriteMask);
    end
  end

`ifdef REGISTER_F_STACK_EN
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned SAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_stack [DEPTH];
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_d;
  logic [CW-1:0]    w_top;
  logic             r_error;
  logic             w_error_d;
  logic             w_push_ok;

  assign w_top = r_count - CW'(1);

  always_comb begin
    w_bank_we = w_lw_we;
    w_bank_d  = w_lw_d;
    w_count_d = r_count;
    w_error_d = r_error;
    w_push_ok = 1'b0;
    if (Pop) begin
      w_bank_we = 1'b0;
      w_bank_d  = w_cur;
      if (r_count != '0) begin
        w_bank_we = 1'b1;
        w_bank_d  = r_stack[w_top[SAW-1:0]];
        w_count_d = w_top;
      end else begin
        w_error_d = 1'b1;
      end
    end else if (Push) begin
      // Push owns the cycle: a coincident BankLoad or write is dropped.
      w_bank_we = 1'b0;
      w_bank_d  = w_cur;
      if (r_count != CW'(DEPTH)) begin
        w_push_ok = 1'b1;
        w_count_d = r_count + CW'(1);
      end else begin
        w_error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_count <= '0;
      r_error <= 1'b0;
    end else begin
      r_count <= w_count_d;
      r_error <= w_error_d;
    end
  end

  // Stack contents are don't-care after reset, so the storage carries no reset.
  always_ff @(posedge Clk) begin
    if (w_push_ok) begin
      r_stack[r_count[SAW-1:0]] <= w_cur;
    end
  end

  assign StackCount = r_count;
  assign StackFull  = (r_count == CW'(DEPTH));
  assign StackEmpty = (r_count == '0);
  assign StackError = r_error;
`else
  logic w_unused_stack;

  assign w_unused_stack = Push ^ Pop;
  assign w_bank_we      = w_lw_we;
  assign w_bank_d       = w_lw_d;
  assign StackCount     = '0;
  assign StackFull      = 1'b0;
  assign StackEmpty     = 1'b1;
  assign StackError     = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < int'(BANKS); i++) begin
        r_bank[i] <= '0;
      end
      r_active <= '0;
    end else begin
      if (w_bank_we) begin
        r_bank[r_active] <= w_bank_d;
      end
      if (Ex) begin
        r_active <= w_next_active;
      end
    end
  end

endmodule

// File: tb/tb_register_f_banked.sv
// Scoreboard bench for register_f_banked: stimulus queues expectations, a monitor checks them.
// Stack scenarios run when REGISTER_F_STACK_EN is defined; otherwise the stackless behaviour.
module tb_register_f_banked;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] FlagIn, FlagWriteMask, DataIn;
  logic       BankLoad, Ex, Push, Pop;
  logic [7:0] F, notF, ShadowF;
  logic [2:0] StackCount;
  logic       StackFull, StackEmpty, StackError;
  logic [7:0] F3, notF3, ShadowF3;
  logic [2:0] StackCount3;
  logic       StackFull3, StackEmpty3, StackError3;
  logic       tb_unused3;

  always #5 Clk = ~Clk;

  register_f_banked #(.WIDTH(8), .BANKS(2), .DEPTH(4)) dut (
    .Clk(Clk), .Reset(Reset), .FlagIn(FlagIn), .FlagWriteMask(FlagWriteMask),
    .BankLoad(BankLoad), .DataIn(DataIn), .Ex(Ex), .Push(Push), .Pop(Pop),
    .F(F), .notF(notF), .ShadowF(ShadowF), .StackCount(StackCount),
    .StackFull(StackFull), .StackEmpty(StackEmpty), .StackError(StackError)
  );

  // Three-bank instance shares the stimulus; only its F is checked where noted.
  register_f_banked #(.WIDTH(8), .BANKS(3), .DEPTH(4)) dut3 (
    .Clk(Clk), .Reset(Reset), .FlagIn(FlagIn), .FlagWriteMask(FlagWriteMask),
    .BankLoad(BankLoad), .DataIn(DataIn), .Ex(Ex), .Push(Push), .Pop(Pop),
    .F(F3), .notF(notF3), .ShadowF(ShadowF3), .StackCount(StackCount3),
    .StackFull(StackFull3), .StackEmpty(StackEmpty3), .StackError(StackError3)
  );

  assign tb_unused3 = ^{notF3, ShadowF3, StackCount3, StackFull3, StackEmpty3, StackError3};

  typedef struct {
    string      name;
    logic [7:0] f;
    logic [7:0] sh;
    logic [2:0] cnt;
    logic       full;
    logic       empty;
    logic       err;
    logic       chk3;
    logic [7:0] f3;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic mon_bad;
  logic [7:0] mon_nf;

  always @(negedge Clk) begin
    if (sb.size() > 0) begin
      mon_e  = sb.pop_front();
      mon_nf = ~mon_e.f;
      n_tests++;
      mon_bad = (F !== mon_e.f) || (notF !== mon_nf) || (ShadowF !== mon_e.sh) ||
                (StackCount !== mon_e.cnt) || (StackFull !== mon_e.full) ||
                (StackEmpty !== mon_e.empty) || (StackError !== mon_e.err) ||
                (mon_e.chk3 && (F3 !== mon_e.f3));
      if (mon_bad) begin
        n_fail++;
        $display("FAIL %s: got F=%h notF=%h Sh=%h cnt=%0d full=%b empty=%b err=%b F3=%h ; want F=%h notF=%h Sh=%h cnt=%0d full=%b empty=%b err=%b F3=%h(chk=%b)",
                 mon_e.name, F, notF, ShadowF, StackCount, StackFull, StackEmpty, StackError,
                 F3, mon_e.f, mon_nf, mon_e.sh, mon_e.cnt, mon_e.full, mon_e.empty, mon_e.err,
                 mon_e.f3, mon_e.chk3);
      end
    end
  end

  task automatic exp_full(input string nm, input logic [7:0] f, input logic [7:0] sh,
                          input logic [2:0] cnt, input logic full, input logic empty,
                          input logic err, input logic chk3, input logic [7:0] f3);
    exp_t e;
    e.name = nm; e.f = f; e.sh = sh; e.cnt = cnt; e.full = full; e.empty = empty;
    e.err = err; e.chk3 = chk3; e.f3 = f3;
    sb.push_back(e);
  endtask

  task automatic exp_s(input string nm, input logic [7:0] f, input logic [7:0] sh,
                       input logic chk3, input logic [7:0] f3);
    exp_full(nm, f, sh, 3'd0, 1'b0, 1'b1, 1'b0, chk3, f3);
  endtask

  task automatic tick(input logic [7:0] fi, input logic [7:0] mk, input logic ld,
                      input logic [7:0] di, input logic ex, input logic ps, input logic pp);
    @(negedge Clk);
    FlagIn = fi; FlagWriteMask = mk; BankLoad = ld; DataIn = di; Ex = ex; Push = ps; Pop = pp;
    @(posedge Clk);
    #1;
    FlagIn = '0; FlagWriteMask = '0; BankLoad = 1'b0; DataIn = '0;
    Ex = 1'b0; Push = 1'b0; Pop = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; FlagIn = '0; FlagWriteMask = '0; DataIn = 8'hFF; BankLoad = 1'b1;
    Ex = 1'b0; Push = 1'b0; Pop = 1'b0;
    @(posedge Clk);
    #1;
    exp_s("reset_hold", 8'h00, 8'h00, 1'b1, 8'h00);
    @(negedge Clk);
    Reset = 1'b0; BankLoad = 1'b0; DataIn = '0;

    //    FlagIn  mask   ld    DataIn ex    push  pop
    tick(8'hFF, 8'hC1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    exp_s("mask_write_c1", 8'hC1, 8'h00, 1'b1, 8'hC1);
    tick(8'h00, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    exp_s("mask_clear_bit0", 8'hC0, 8'h00, 1'b0, 8'h00);
    tick(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    exp_s("mask_zero_noop", 8'hC0, 8'h00, 1'b0, 8'h00);
    tick(8'h00, 8'hFF, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    exp_s("load_over_write", 8'h55, 8'h00, 1'b1, 8'h55);
    tick(8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    exp_s("ex_to_bank1", 8'h00, 8'h55, 1'b1, 8'h00);
    tick(8'h00, 8'h00, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    exp_s("load_bank1", 8'hAA, 8'h55, 1'b0, 8'h00);
    tick(8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    exp_s("ex_wrap_to0", 8'h55, 8'hAA, 1'b1, 8'h00);
    tick(8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    exp_s("ex3_returns", 8'hAA, 8'h55, 1'b1, 8'h55);
    tick(8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    exp_s("ex_back0", 8'h55, 8'hAA, 1'b1, 8'hAA);
    tick(8'h10, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    exp_s("write_10", 8'h10, 8'hAA, 1'b1, 8'h10);
    tick(8'h80, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    exp_s("ex_with_write", 8'hAA, 8'h80, 1'b1, 8'h00);
    tick(8'h00, 8'h00, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
    exp_s("ex_with_load", 8'h80, 8'h33, 1'b1, 8'h55);

`ifdef REGISTER_F_STACK_EN
    for (int k = 1; k <= 4; k++) begin
      tick(8'(k), 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      exp_full("stk_write", 8'(k), 8'h33, 3'(k - 1), 1'b0, (k == 1), 1'b0, 1'b0, 8'h00);
      tick(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      exp_full("stk_push", 8'(k), 8'h33, 3'(k), (k == 4), 1'b0, 1'b0, 1'b0, 8'h00);
    end
    tick(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    exp_full("push_when_full", 8'h04, 8'h33, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    for (int k = 4; k >= 1; k--) begin
      tick(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      exp_full("stk_pop", 8'(k), 8'h33, 3'(k - 1), 1'b0, (k == 1), 1'b1, 1'b0, 8'h00);
    end
    tick(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    exp_full("pop_when_empty", 8'h01, 8'h33, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    tick(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    exp_full("push_again", 8'h01, 8'h33, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    tick(8'h77, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    exp_full("write_77", 8'h77, 8'h33, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    tick(8'h00, 8'h00, 1'b1, 8'hEE, 1'b0, 1'b1, 1'b1);
    exp_full("pop_beats_all", 8'h01, 8'h33, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
`else
    tick(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    exp_s("nostack_push", 8'h80, 8'h33, 1'b0, 8'h00);
    tick(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    exp_s("nostack_pop", 8'h80, 8'h33, 1'b0, 8'h00);
    tick(8'h00, 8'h00, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b1);
    exp_s("nostack_load_wins", 8'h0F, 8'h33, 1'b0, 8'h00);
`endif

    // Reset arrives mid-cycle while a load is pending; the load is abandoned.
    @(negedge Clk);
    BankLoad = 1'b1; DataIn = 8'h5A;
    #2 Reset = 1'b1;
    @(posedge Clk);
    #1;
    exp_s("reset_mid", 8'h00, 8'h00, 1'b1, 8'h00);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    BankLoad = 1'b0; DataIn = '0;
    exp_s("post_reset_load", 8'h5A, 8'h00, 1'b1, 8'h5A);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge Clk);
    #1;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/register_f_banked.md
REGISTER_F_BANKED -- requirements
Module: register_f_banked

Interface
REQ-001 SHALL have parameter WIDTH, default 8, flag bits per bank.
REQ-002 SHALL have parameter BANKS, default 2, number of flag banks (main plus shadows); legal values 2..8.
REQ-003 SHALL have parameter DEPTH, default 4, flag save-stack entries; legal values 1..16.
REQ-004 SHALL have port Clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port FlagIn, input, WIDTH, new flag values from the ALU and flag-select logic.
REQ-007 SHALL have port FlagWriteMask, input, WIDTH, per-bit write enable for FlagIn.
REQ-008 SHALL have port BankLoad, input, 1, full-width load of DataIn into the active bank (POP AF path).
REQ-009 SHALL have port DataIn, input, WIDTH, bus data for BankLoad.
REQ-010 SHALL have port Ex, input, 1, rotate the active bank pointer (EX AF,AF' generalised).
REQ-011 SHALL have port Push, input, 1, save active bank contents to the stack (interrupt entry).
REQ-012 SHALL have port Pop, input, 1, restore active bank contents from the stack (interrupt return).
REQ-013 SHALL have port F, output, WIDTH, active-bank flags, registered.
REQ-014 SHALL have port notF, output, WIDTH, bitwise complement of F.
REQ-015 SHALL have port ShadowF, output, WIDTH, contents of bank (active+1) mod BANKS.
REQ-016 SHALL have port StackCount, output, clog2(DEPTH+1), number of occupied stack entries.
REQ-017 SHALL have port StackFull, output, 1, StackCount==DEPTH.
REQ-018 SHALL have port StackEmpty, output, 1, StackCount==0.
REQ-019 SHALL have port StackError, output, 1, sticky flag for push-when-full or pop-when-empty.

Function
REQ-020 SHALL resolve same-cycle commands by priority Pop > Push > BankLoad > masked write; Ex is independent of this priority and always applies.
REQ-021 SHALL, on masked write, set bit i of the active bank to FlagIn[i] when FlagWriteMask[i]=1 and retain it otherwise; an all-zero mask is a no-op.
REQ-022 SHALL, on BankLoad, replace all WIDTH bits of the active bank with DataIn, ignoring FlagWriteMask.
REQ-023 SHALL, on Ex, set active pointer to (active+1) mod BANKS, wrapping from BANKS-1 to 0.
REQ-024 SHALL, when Ex coincides with a write, BankLoad or Pop, apply the data change to the bank active before the edge, then advance the pointer.
REQ-025 SHALL, on Push when not full, store the active bank at stack[StackCount] and increment StackCount; the active bank is unchanged.
REQ-026 SHALL, on Pop when not empty, load the active bank from stack[StackCount-1] and decrement StackCount.
REQ-027 SHALL, on Push when full or Pop when empty, leave stack, count and banks unchanged and set StackError; StackError clears only on Reset.
REQ-028 SHALL, on simultaneous Push and Pop, perform Pop only (REQ-020); Push is dropped without error.
REQ-029 SHALL drive F, notF and ShadowF from registers/bank state with one-cycle latency from the command edge and no combinational path from inputs.

Reset
REQ-030 SHALL, while Reset=1, force all banks to 0, active pointer to 0, StackCount to 0 and StackError to 0, independent of Clk.
REQ-031 SHALL output F=0, notF=all ones, ShadowF=0, StackEmpty=1, StackFull=0 during and after reset; stack entry contents are don't-care.
REQ-032 SHALL abandon any command in flight when Reset asserts mid-cycle; the first post-reset edge acts on the current inputs.

Configuration
REQ-033 SHALL, with macro REGISTER_F_STACK_EN defined, implement the save stack per REQ-025..028.
REQ-034 SHALL, without REGISTER_F_STACK_EN, omit stack storage; Push/Pop are ignored, StackCount=0, StackEmpty=1, StackFull=0, StackError=0, and Pop loses priority so BankLoad heads the order.

Verification
REQ-035 SHALL cover: reset, FlagIn=8'hFF, mask=8'b1100_0001, write -> F=8'hC1, notF=8'h3E.
REQ-036 SHALL cover: BANKS=2, bank0=8'h55, Ex, BankLoad DataIn=8'hAA, Ex -> F=8'h55, ShadowF=8'hAA.
REQ-037 SHALL cover: BANKS=3, three Ex pulses -> active returns to 0, F equals value before the first Ex.
REQ-038 SHALL cover: DEPTH=4, push 8'h01..8'h04, fifth push -> StackFull=1, StackError=1, StackCount=4; four pops -> F=8'h01, StackEmpty=1.
REQ-039 SHALL cover: F=8'h10, same-cycle Ex and mask=8'hFF write FlagIn=8'h80 -> bank0=8'h80, F=bank1 value, ShadowF=8'h80.
REQ-040 SHALL cover: build without REGISTER_F_STACK_EN, Push then Pop -> F unchanged, StackCount=0, StackError=0.
